// File: rtl/ctrl_step_sequencer_pkg.sv
// Shared definitions for the control-word step sequencer: default geometry and
// the sequencer state type.
package ctrl_step_sequencer_pkg;

    localparam int unsigned SEQ_CTRL_W = 64;
    localparam int unsigned SEQ_DEPTH  = 16;
    localparam int unsigned SEQ_HOLD_W = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_PAUSE,
        SEQ_DONE
    } seq_state_e;

endpackage

// File: rtl/ctrl_step_sequencer_if.sv
// Programming/control/status bundle between the controller (master) and the
// step sequencer (slave).
interface ctrl_step_sequencer_if #(
    parameter int unsigned CTRL_W = ctrl_step_sequencer_pkg::SEQ_CTRL_W,
    parameter int unsigned DEPTH  = ctrl_step_sequencer_pkg::SEQ_DEPTH,
    parameter int unsigned HOLD_W = ctrl_step_sequencer_pkg::SEQ_HOLD_W
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              iWrEn;
    logic [IDX_W-1:0]  iWrAddr;
    logic [CTRL_W-1:0] iWrCtrl;
    logic [HOLD_W-1:0] iWrHold;
    logic              iWrLast;
    logic              iStart;
    logic              iLoop;
    logic              iStepMode;
    logic              iStep;
    logic              iAbort;
    logic [CTRL_W-1:0] oCtrl;
    logic [IDX_W-1:0]  oStepIdx;
    logic              oStepStrobe;
    logic              oBusy;
    logic              oDone;

    modport master (
        output iWrEn, iWrAddr, iWrCtrl, iWrHold, iWrLast,
        output iStart, iLoop, iStepMode, iStep, iAbort,
        input  oCtrl, oStepIdx, oStepStrobe, oBusy, oDone
    );

    modport slave (
        input  iWrEn, iWrAddr, iWrCtrl, iWrHold, iWrLast,
        input  iStart, iLoop, iStepMode, iStep, iAbort,
        output oCtrl, oStepIdx, oStepStrobe, oBusy, oDone
    );

endinterface

// File: rtl/ctrl_step_sequencer_seq_table.sv
// Step table: DEPTH entries of {last, hold, ctrl}, synchronous write, two
// asynchronous read ports (last flag of current step, body of the next step).
module ctrl_seq_table
    import ctrl_step_sequencer_pkg::*;
#(
    parameter int unsigned CTRL_W = SEQ_CTRL_W,
    parameter int unsigned DEPTH  = SEQ_DEPTH,
    parameter int unsigned HOLD_W = SEQ_HOLD_W,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic              wr_last,
    input  logic [IDX_W-1:0]  rd_addr_a,
    output logic              rd_last_a,
    input  logic [IDX_W-1:0]  rd_addr_b,
    output logic [CTRL_W-1:0] rd_ctrl_b,
    output logic [HOLD_W-1:0] rd_hold_b
);

    typedef struct packed {
        logic              last;
        logic [HOLD_W-1:0] hold;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = '{last: wr_last, hold: wr_hold, ctrl: wr_ctrl};
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_last_a = mem_q[rd_addr_a].last;
    assign rd_ctrl_b = mem_q[rd_addr_b].ctrl;
    assign rd_hold_b = mem_q[rd_addr_b].hold;

endmodule

// File: rtl/ctrl_step_sequencer.sv
// Table-driven control-word sequencer: replays programmed steps, each held for
// hold+1 cycles, with free-run, loop and single-step modes.
module ctrl_step_sequencer
    import ctrl_step_sequencer_pkg::*;
#(
    parameter int unsigned CTRL_W = SEQ_CTRL_W,
    parameter int unsigned DEPTH  = SEQ_DEPTH,
    parameter int unsigned HOLD_W = SEQ_HOLD_W
) (
    input logic                  iClk,
    input logic                  iRst,
    ctrl_step_sequencer_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              loop_q, loop_d;
    logic              step_q, step_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tbl_last;
    logic [CTRL_W-1:0] nxt_ctrl;
    logic [HOLD_W-1:0] nxt_hold;
    logic [IDX_W-1:0]  nxt_addr;
    logic              cur_last;
    logic              load;

    ctrl_seq_table #(
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) u_table (
        .clk       (iClk),
        .wr_en     (bus.iWrEn && (state_q == SEQ_IDLE)),
        .wr_addr   (bus.iWrAddr),
        .wr_ctrl   (bus.iWrCtrl),
        .wr_hold   (bus.iWrHold),
        .wr_last   (bus.iWrLast),
        .rd_addr_a (idx_q),
        .rd_last_a (tbl_last),
        .rd_addr_b (nxt_addr),
        .rd_ctrl_b (nxt_ctrl),
        .rd_hold_b (nxt_hold)
    );

    // The final table slot ends the sequence even without its last flag.
    assign cur_last = tbl_last || (idx_q == LAST_IDX);
    assign nxt_addr = (((state_q == SEQ_RUN) && !cur_last) || (state_q == SEQ_PAUSE))
                      ? idx_q + 1'b1 : '0;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= SEQ_IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            loop_q   <= 1'b0;
            step_q   <= 1'b0;
            ctrl_q   <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            loop_q   <= loop_d;
            step_q   <= step_d;
            ctrl_q   <= ctrl_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        step_d  = step_q;
        load    = 1'b0;
        if (bus.iAbort) begin
            state_d = SEQ_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (bus.iStart) begin
                        state_d = SEQ_RUN;
                        idx_d   = '0;
                        loop_d  = bus.iLoop;
                        step_d  = bus.iStepMode;
                        load    = 1'b1;
                    end
                end
                SEQ_RUN: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if (!cur_last && !step_q) begin
                        idx_d = idx_q + 1'b1;
                        load  = 1'b1;
                    end else if (!cur_last) begin
                        state_d = SEQ_PAUSE;
                    end else if (loop_q && !step_q) begin
                        idx_d = '0;
                        load  = 1'b1;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
                SEQ_PAUSE: begin
                    if (bus.iStep) begin
                        state_d = SEQ_RUN;
                        idx_d   = idx_q + 1'b1;
                        load    = 1'b1;
                    end
                end
                SEQ_DONE: state_d = SEQ_IDLE;
                default:  state_d = SEQ_IDLE;
            endcase
        end
        if (load) begin
            hold_d = nxt_hold;
        end
    end

    // A load marks the first cycle of a step; otherwise RUN keeps the word.
    always_comb begin
        ctrl_d   = '0;
        strobe_d = 1'b0;
        busy_d   = (state_d == SEQ_RUN) || (state_d == SEQ_PAUSE);
        done_d   = (state_q == SEQ_RUN) && (state_d == SEQ_DONE);
        if (load) begin
            ctrl_d   = nxt_ctrl;
            strobe_d = 1'b1;
        end else if (state_d == SEQ_RUN) begin
            ctrl_d = ctrl_q;
        end
    end

    assign bus.oCtrl       = ctrl_q;
    assign bus.oStepIdx    = idx_q;
    assign bus.oStepStrobe = strobe_q;
    assign bus.oBusy       = busy_q;
    assign bus.oDone       = done_q;

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Self-checking bench for ctrl_step_sequencer: a shadow copy of the step table
// is expanded into expected per-cycle output records and compared every cycle.
module tb_ctrl_step_sequencer;

    localparam int unsigned CTRL_W = 64;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned IDX_W  = 4;

    // {ctrl, idx, strobe, busy, done}
    typedef logic [CTRL_W+IDX_W+2:0] rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    logic [CTRL_W-1:0] m_ctrl [DEPTH];
    int                m_hold [DEPTH];
    bit                m_last [DEPTH];
    rec_t              exp_q [$];

    ctrl_step_sequencer_if #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus ();

    ctrl_step_sequencer #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(logic [CTRL_W-1:0] c, int i, bit s, bit b, bit d);
        logic [IDX_W-1:0] ix = IDX_W'(i);
        return {c, ix, s, b, d};
    endfunction

    function automatic rec_t observe();
        return {bus.oCtrl, bus.oStepIdx, bus.oStepStrobe, bus.oBusy, bus.oDone};
    endfunction

    function automatic int last_of();
        for (int i = 0; i < int'(DEPTH); i++) if (m_last[i]) return i;
        return int'(DEPTH) - 1;
    endfunction

    // One pass of the sequence: each step appears hold+1 times, strobe on its first cycle.
    function automatic void push_pass();
        for (int i = 0; i <= last_of(); i++)
            for (int c = 0; c <= m_hold[i]; c++)
                exp_q.push_back(mk(m_ctrl[i], i, c == 0, 1'b1, 1'b0));
    endfunction

    task automatic drive_idle();
        bus.iWrEn = 1'b0; bus.iWrAddr = '0; bus.iWrCtrl = '0; bus.iWrHold = '0;
        bus.iWrLast = 1'b0; bus.iStart = 1'b0; bus.iLoop = 1'b0; bus.iStepMode = 1'b0;
        bus.iStep = 1'b0; bus.iAbort = 1'b0;
    endtask

    task automatic write_entry(int a, logic [CTRL_W-1:0] c, int h, bit l);
        bus.iWrEn = 1'b1; bus.iWrAddr = IDX_W'(a); bus.iWrCtrl = c;
        bus.iWrHold = HOLD_W'(h); bus.iWrLast = l;
        @(negedge clk);
        bus.iWrEn = 1'b0;
        m_ctrl[a] = c; m_hold[a] = h; m_last[a] = l;
    endtask

    task automatic load_basic();
        write_entry(0, 64'h11, 0, 1'b0);
        write_entry(1, 64'h22, 2, 1'b0);
        write_entry(2, 64'h33, 0, 1'b1);
    endtask

    task automatic load_random(int len, bit no_last);
        for (int i = 0; i < int'(DEPTH); i++)
            write_entry(i, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                        !no_last && (i == len - 1));
    endtask

    task automatic test_reset();
        rec_t act;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            act = observe();
            checks++;
            if (act !== mk('0, 0, 0, 0, 0))
                $display("FAIL reset cyc=%0d got=%h want=%h", k, act, mk('0, 0, 0, 0, 0));
            else passed++;
        end
    endtask

    task automatic test_free_run(string name);
        rec_t act;
        int   l = last_of();
        exp_q.delete();
        push_pass();
        exp_q.push_back(mk('0, l, 0, 0, 1));
        exp_q.push_back(mk('0, l, 0, 0, 0));
        exp_q.push_back(mk('0, l, 0, 0, 0));
        bus.iStart = 1'b1; bus.iLoop = 1'b0; bus.iStepMode = 1'b0;
        foreach (exp_q[k]) begin
            @(negedge clk);
            bus.iStart = 1'b0;
            act = observe();
            checks++;
            if (act !== exp_q[k])
                $display("FAIL %s cyc=%0d got=%h want=%h", name, k, act, exp_q[k]);
            else passed++;
        end
    endtask

    task automatic test_loop_abort(string name);
        rec_t act;
        int   p, k;
        exp_q.delete();
        push_pass();
        p = exp_q.size();
        push_pass();
        push_pass();
        k = int'($urandom_range(0, p - 1));
        while (exp_q.size() > 2 * p + k) void'(exp_q.pop_back());
        for (int j = 0; j < 4; j++) exp_q.push_back(mk('0, 0, 0, 0, 0));
        bus.iStart = 1'b1; bus.iLoop = 1'b1; bus.iStepMode = 1'b0;
        foreach (exp_q[n]) begin
            @(negedge clk);
            bus.iStart = 1'b0; bus.iLoop = 1'b0;
            bus.iAbort = (n == 2 * p + k - 1);
            act = observe();
            checks++;
            if (act !== exp_q[n])
                $display("FAIL %s cyc=%0d got=%h want=%h", name, n, act, exp_q[n]);
            else passed++;
        end
        bus.iAbort = 1'b0;
    endtask

    task automatic test_step_mode(string name);
        rec_t act, want;
        int   l = last_of();
        int   cyc = 0;
        int   gap;
        bus.iStart = 1'b1; bus.iLoop = 1'b0; bus.iStepMode = 1'b1;
        for (int i = 0; i <= l; i++) begin
            for (int c = 0; c <= m_hold[i]; c++) begin
                @(negedge clk);
                bus.iStart = 1'b0; bus.iStepMode = 1'b0; bus.iStep = 1'b0;
                want = mk(m_ctrl[i], i, c == 0, 1'b1, 1'b0);
                act = observe();
                checks++;
                if (act !== want) $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
                else passed++;
                cyc++;
            end
            if (i < l) begin
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g <= gap; g++) begin
                    @(negedge clk);
                    want = mk('0, i, 0, 1, 0);
                    act = observe();
                    checks++;
                    if (act !== want) $display("FAIL %s_pause cyc=%0d got=%h want=%h", name, cyc, act, want);
                    else passed++;
                    cyc++;
                end
                bus.iStep = 1'b1;
            end
        end
        @(negedge clk);
        want = mk('0, l, 0, 0, 1);
        act = observe();
        checks++;
        if (act !== want) $display("FAIL %s_done got=%h want=%h", name, act, want);
        else passed++;
        bus.iStep = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            bus.iStep = 1'b0;
            want = mk('0, l, 0, 0, 0);
            act = observe();
            checks++;
            if (act !== want) $display("FAIL %s_idle_step j=%0d got=%h want=%h", name, j, act, want);
            else passed++;
        end
    endtask

    task automatic test_ignored();
        rec_t act, want;
        load_basic();
        exp_q.delete();
        push_pass();
        exp_q.push_back(mk('0, 2, 0, 0, 1));
        exp_q.push_back(mk('0, 2, 0, 0, 0));
        for (int run = 0; run < 2; run++) begin
            bus.iStart = 1'b1;
            foreach (exp_q[k]) begin
                @(negedge clk);
                bus.iStart = 1'b0; bus.iWrEn = 1'b0;
                if (run == 0 && k == 1) begin
                    bus.iWrEn = 1'b1; bus.iWrAddr = IDX_W'(1); bus.iWrCtrl = 64'hDEAD;
                    bus.iWrHold = '0; bus.iWrLast = 1'b1; bus.iStart = 1'b1;
                end
                act = observe();
                checks++;
                if (act !== exp_q[k])
                    $display("FAIL busy_ignore run=%0d cyc=%0d got=%h want=%h", run, k, act, exp_q[k]);
                else passed++;
            end
        end
        bus.iAbort = 1'b1; bus.iStart = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.iAbort = 1'b0; bus.iStart = 1'b0;
            want = mk('0, 0, 0, 0, 0);
            act = observe();
            checks++;
            if (act !== want) $display("FAIL abort_start j=%0d got=%h want=%h", j, act, want);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        rec_t act, want;
        load_basic();
        exp_q.delete();
        push_pass();
        bus.iStart = 1'b1; bus.iLoop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.iStart = 1'b0; bus.iLoop = 1'b0;
            act = observe();
            checks++;
            if (act !== exp_q[k]) $display("FAIL rst_mid_pre cyc=%0d got=%h want=%h", k, act, exp_q[k]);
            else passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        want = mk('0, 0, 0, 0, 0);
        for (int j = 0; j < 2; j++) begin
            act = observe();
            checks++;
            if (act !== want) $display("FAIL rst_mid j=%0d got=%h want=%h", j, act, want);
            else passed++;
            @(negedge clk);
        end
        test_free_run("rst_replay");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench did not finish");
    end

    initial begin
        drive_idle();
        test_reset();
        load_basic();
        test_free_run("basic");
        test_step_mode("step_basic");
        test_loop_abort("loop_basic");
        test_ignored();
        test_reset_mid();
        load_random(16, 1'b1);
        test_free_run("full_depth");
        for (int it = 0; it < 8; it++) begin
            load_random(int'($urandom_range(1, 16)), 1'b0);
            test_free_run("rand_free");
        end
        for (int it = 0; it < 3; it++) begin
            load_random(int'($urandom_range(1, 6)), 1'b0);
            test_step_mode("rand_step");
            load_random(int'($urandom_range(1, 5)), 1'b0);
            test_loop_abort("rand_loop");
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
